// File: rtl/uart_tx.sv
// UART serial transmitter: accepts a word over valid/ready and sends start, data (LSB first),
// optional parity and stop bits on sdata, with bit timing derived from the system clock.
module uart_tx #(
    parameter int BYTESIZES           = 8,
    parameter int BAUDRATE            = 115200,
    parameter int COUNTER_CLOCK_INPUT = 50_000_000,
    parameter int PARITY              = 0,
    parameter int STOPBITS            = 1
) (
    input  logic                 clock,
    input  logic                 nreset,
    input  logic [BYTESIZES-1:0] datain,
    input  logic                 valid,
    output logic                 ready,
    output logic                 sdata,
    output logic                 busy,
    output logic                 done
);
    localparam int CLKS_PER_BIT = COUNTER_CLOCK_INPUT / BAUDRATE;
    localparam int CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = (BYTESIZES < 2) ? 1 : $clog2(BYTESIZES);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(BYTESIZES - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOPBITS - 1);

    if (CLKS_PER_BIT < 2 || PARITY < 0 || PARITY > 2 ||
        (STOPBITS != 1 && STOPBITS != 2) || BYTESIZES < 1) begin : g_param_check
        $error("uart_tx: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [BYTESIZES-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 sdata_q, sdata_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 accept_s, bit_end_s, pre_last_s;
    logic [BYTESIZES-1:0] shreg_shift_s;

    function automatic logic parity_f(input logic [BYTESIZES-1:0] w);
        if (PARITY == 2) begin
            parity_f = ~(^w);
        end else begin
            parity_f = ^w;
        end
    endfunction

    assign accept_s      = valid && ready_q;
    assign bit_end_s     = (cnt_q == CNT_LAST);
    assign shreg_shift_s = shreg_q >> 1;
    // ready/done are registered, so they are raised one clock ahead of the final stop clock
    assign pre_last_s    = (state_q == S_STOP) && (idx_q == STOP_LAST) && (cnt_q == CNT_PRE);

    // Next-state, datapath and registered-output precomputation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        sdata_d = sdata_q;
        case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                idx_d   = '0;
                sdata_d = 1'b1;
                if (accept_s) begin
                    state_d = S_START;
                    shreg_d = datain;
                    par_d   = parity_f(datain);
                    sdata_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                    sdata_d = shreg_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    cnt_d = '0;
                    if (idx_q == DATA_LAST) begin
                        idx_d = '0;
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            sdata_d = par_q;
                        end else begin
                            state_d = S_STOP;
                            sdata_d = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shreg_d = shreg_shift_s;
                        sdata_d = shreg_shift_s[0];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (bit_end_s) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                    idx_d   = '0;
                    sdata_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_end_s) begin
                    cnt_d = '0;
                    if (idx_q == STOP_LAST) begin
                        idx_d = '0;
                        // accept on the final stop clock chains straight into the next start bit
                        if (accept_s) begin
                            state_d = S_START;
                            shreg_d = datain;
                            par_d   = parity_f(datain);
                            sdata_d = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                            sdata_d = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
                sdata_d = 1'b1;
            end
        endcase
        ready_d = (state_d == S_IDLE) || pre_last_s;
        busy_d  = (state_d != S_IDLE);
        done_d  = pre_last_s;
    end

    // State and output registers
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            sdata_q <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            sdata_q <= sdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ready = ready_q;
    assign sdata = sdata_q;
    assign busy  = busy_q;
    assign done  = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: four instances (no parity, even, odd, two stop bits) at 16 clocks/bit.
module tb_uart_tx;
    localparam int CPB = 16;
    localparam int NI  = 4;

    typedef struct {
        int          inst;
        int          acc;
        logic [15:0] bits;
        int          nbits;
        bit          aborts;
    } exp_t;

    logic          clock = 1'b0;
    logic          nreset;
    logic [7:0]    datain_s [NI];
    logic [NI-1:0] valid_s;
    logic [NI-1:0] ready_s;
    logic [NI-1:0] sdata_s;
    logic [NI-1:0] busy_s;
    logic [NI-1:0] done_s;
    int            cyc    = 0;
    int            n_cmp  = 0;
    int            n_fail = 0;
    exp_t          exp_q[$];

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    for (genvar k = 0; k < NI; k++) begin : g_dut
        uart_tx #(
            .BYTESIZES          (8),
            .BAUDRATE           (1),
            .COUNTER_CLOCK_INPUT(16),
            .PARITY             ((k == 1) ? 1 : ((k == 2) ? 2 : 0)),
            .STOPBITS           ((k == 3) ? 2 : 1)
        ) u_dut (
            .clock (clock),
            .nreset(nreset),
            .datain(datain_s[k]),
            .valid (valid_s[k]),
            .ready (ready_s[k]),
            .sdata (sdata_s[k]),
            .busy  (busy_s[k]),
            .done  (done_s[k])
        );

        // Monitor: detects a start bit, pops the expected frame and checks every clock of it
        initial begin : mon
            exp_t e;
            bit   prev;
            bit   skip;
            bit   aborted;
            bit   ok;
            int   len;
            int   sbad;
            int   dbad;
            int   bbad;
            int   rbad;
            prev = 1'b1;
            skip = 1'b0;
            forever begin
                if (!skip) @(negedge clock);
                skip = 1'b0;
                if (nreset === 1'b1 && prev && sdata_s[k] === 1'b0) begin
                    ok = (exp_q.size() != 0) && (exp_q[0].inst == k);
                    chk($sformatf("inst%0d_frame_expected", k), int'(ok), 1);
                    if (ok) begin
                        e = exp_q.pop_front();
                        chk($sformatf("inst%0d_start_cycle", k), cyc, e.acc);
                        len     = e.nbits * CPB;
                        sbad    = 0;
                        dbad    = 0;
                        bbad    = 0;
                        rbad    = 0;
                        aborted = 1'b0;
                        for (int t = 0; t < len; t++) begin
                            if (t > 0) @(negedge clock);
                            if (nreset !== 1'b1) begin
                                aborted = 1'b1;
                                break;
                            end
                            if (sdata_s[k] !== e.bits[t / CPB]) sbad++;
                            if (done_s[k] !== (t == len - 1)) dbad++;
                            if (busy_s[k] !== 1'b1) bbad++;
                            if (ready_s[k] !== (t == len - 1)) rbad++;
                            if ((t % CPB) == CPB - 1) begin
                                chk($sformatf("inst%0d_bit%0d_wrong_clocks", k, t / CPB), sbad, 0);
                                sbad = 0;
                            end
                        end
                        chk($sformatf("inst%0d_aborted", k), int'(aborted), int'(e.aborts));
                        if (!aborted) begin
                            chk($sformatf("inst%0d_done_wrong_clocks", k), dbad, 0);
                            chk($sformatf("inst%0d_busy_low_clocks", k), bbad, 0);
                            chk($sformatf("inst%0d_ready_wrong_clocks", k), rbad, 0);
                            @(negedge clock);
                            if (nreset === 1'b1 && sdata_s[k] === 1'b0) begin
                                skip = 1'b1;
                            end else if (nreset === 1'b1) begin
                                chk($sformatf("inst%0d_busy_after_frame", k), int'(busy_s[k]), 0);
                                chk($sformatf("inst%0d_ready_after_frame", k), int'(ready_s[k]), 1);
                            end
                        end
                        prev = 1'b1;
                    end else begin
                        prev = sdata_s[k];
                    end
                end else begin
                    prev = sdata_s[k];
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accept edge
    task automatic send(input int inst, input logic [7:0] d, input logic [15:0] bits,
                        input int nbits, input bit aborts, output int acc);
        exp_t e;
        int   n;
        datain_s[inst] = d;
        valid_s[inst]  = 1'b1;
        n = 0;
        while (ready_s[inst] !== 1'b1 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        chk($sformatf("inst%0d_accept_timeout", inst), int'(n >= 1000), 0);
        acc = cyc + 1;
        if (n < 1000) begin
            e.inst   = inst;
            e.acc    = acc;
            e.bits   = bits;
            e.nbits  = nbits;
            e.aborts = aborts;
            exp_q.push_back(e);
        end
        @(negedge clock);
        valid_s[inst]  = 1'b0;
        datain_s[inst] = ~d;
    endtask

    task automatic wait_idle(input int inst);
        int n;
        n = 0;
        @(negedge clock);
        while (busy_s[inst] !== 1'b0 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        chk($sformatf("inst%0d_idle_timeout", inst), int'(n >= 1000), 0);
        repeat (3) @(negedge clock);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Frame constants: bit 0 is the start bit, then data LSB first, parity, stop bits
    initial begin : stim
        int a1;
        int a2;
        nreset  = 1'b0;
        valid_s = '0;
        for (int k = 0; k < NI; k++) datain_s[k] = 8'h00;
        #12;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("inst%0d_reset_sdata", k), int'(sdata_s[k]), 1);
            chk($sformatf("inst%0d_reset_ready", k), int'(ready_s[k]), 1);
            chk($sformatf("inst%0d_reset_busy", k), int'(busy_s[k]), 0);
            chk($sformatf("inst%0d_reset_done", k), int'(done_s[k]), 0);
        end
        @(negedge clock);
        nreset = 1'b1;
        @(negedge clock);

        send(0, 8'hA5, 16'h034A, 10, 1'b0, a1);
        wait_idle(0);
        send(1, 8'h07, 16'h060E, 11, 1'b0, a1);
        wait_idle(1);
        send(2, 8'h07, 16'h040E, 11, 1'b0, a1);
        wait_idle(2);
        send(2, 8'h00, 16'h0600, 11, 1'b0, a1);
        wait_idle(2);

        send(0, 8'h00, 16'h0200, 10, 1'b0, a1);
        send(0, 8'hFF, 16'h03FE, 10, 1'b0, a2);
        chk("b2b_accept_spacing", a2 - a1, 160);
        wait_idle(0);

        send(0, 8'h96, 16'h032C, 10, 1'b0, a1);
        repeat (40) @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            valid_s[0]  = 1'b1;
            datain_s[0] = 8'h3C ^ 8'(i);
            @(negedge clock);
            chk($sformatf("ignored_valid_ready_%0d", i), int'(ready_s[0]), 0);
        end
        valid_s[0] = 1'b0;
        wait_idle(0);

        send(0, 8'hC3, 16'h0386, 10, 1'b1, a1);
        repeat (70) @(negedge clock);
        #2;
        nreset = 1'b0;
        #1;
        chk("midframe_reset_sdata", int'(sdata_s[0]), 1);
        chk("midframe_reset_ready", int'(ready_s[0]), 1);
        chk("midframe_reset_busy", int'(busy_s[0]), 0);
        chk("midframe_reset_done", int'(done_s[0]), 0);
        repeat (3) @(negedge clock);
        nreset = 1'b1;
        @(negedge clock);
        send(0, 8'h81, 16'h0302, 10, 1'b0, a1);
        wait_idle(0);

        send(3, 8'hFF, 16'h07FE, 11, 1'b0, a1);
        wait_idle(3);

        repeat (5) @(negedge clock);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
